ahbextram: RTL and testbench

AHB-Lite slave memory attached to the SoC external bus port: it consumes the address/control/write-data outputs of the SoC top and returns HRDATAEXT/HREADYEXT/HRESPEXT. It models off-chip RAM with a programmable number of wait states, byte-strobed writes and ERROR responses for illegal accesses. It is used in simulation and FPGA builds as the default external memory behind HSELEXT.

---
 rtl/ahbextram.sv | 167 ++++++++++++++++
 tb/tb_ahbextram.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbextram.sv
// ahbextram: AHB-Lite slave modelling off-chip RAM with wait states, byte strobes and ERROR responses.
// Latency: OKAY data phase lasts WAIT_STATES+1 cycles; an ERROR response always lasts two cycles.
// Backpressure: HREADYEXT is low during wait states and the first ERROR cycle; address phases are taken only in IDLE/DONE/ERR2 with HREADY high.
module ahbextram #(
    parameter int                 AHBW        = 64,
    parameter int                 PA_BITS     = 32,
    parameter logic [PA_BITS-1:0] BASE        = 32'h8000_0000,
    parameter int                 SIZE_BYTES  = 32768,
    parameter int                 WAIT_STATES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                HSELEXT,
    input  logic [PA_BITS-1:0]  HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [2:0]          HBURST,
    input  logic                HREADY,
    input  logic [AHBW-1:0]     HWDATA,
    input  logic [AHBW/8-1:0]   HWSTRB,
    output logic [AHBW-1:0]     HRDATAEXT,
    output logic                HREADYEXT,
    output logic                HRESPEXT
);
    localparam int NB    = AHBW / 8;
    localparam int OFS   = $clog2(NB);
    localparam int WORDS = SIZE_BYTES / NB;
    localparam int IDX_W = $clog2(WORDS);
    localparam int CW    = 4;

    // Decode window computed one bit wider so BASE+SIZE_BYTES cannot wrap.
    localparam logic [PA_BITS:0] LO = {1'b0, BASE};
    localparam logic [PA_BITS:0] HI = LO + (PA_BITS+1)'(SIZE_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t           state;
    state_t           nxt_state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    nxt_cnt;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] nxt_idx;
    logic             wr_q;
    logic             nxt_wr;

    logic [AHBW-1:0]  mem [WORDS];

    logic [PA_BITS-1:0] off;
    logic [PA_BITS-1:0] amask;
    logic [IDX_W-1:0]   a_idx;
    logic               range_bad;
    logic               size_bad;
    logic               align_bad;
    logic               a_err;
    logic               can_take;
    logic               accept;
    logic               bypass;
    logic [AHBW-1:0]    rd_word;
    logic [AHBW-1:0]    nxt_rdata;
    logic               unused_ok;

    // Address-phase decode: word index and the illegal-access checks.
    assign off       = HADDR - BASE;
    assign a_idx     = off[OFS +: IDX_W];
    assign amask     = ~({PA_BITS{1'b1}} << HSIZE);
    assign range_bad = ({1'b0, HADDR} < LO) || ({1'b0, HADDR} >= HI);
    assign size_bad  = HSIZE > 3'(OFS);
    assign align_bad = (HADDR & amask) != '0;
    assign a_err     = range_bad | size_bad | align_bad;

    // A new address phase is only taken while the previous data phase is completing.
    assign can_take  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR2);
    assign accept    = can_take & HSELEXT & HREADY & HTRANS[1];

    // HBURST is informational, SEQ/NONSEQ are treated alike, and only the index bits of the offset matter.
    assign unused_ok = ^{HBURST, HTRANS[0], off};

    // Next-state decision for the transfer FSM.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_idx   = idx_q;
        nxt_wr    = wr_q;
        case (state)
            S_WAIT: begin
                if (cnt == '0) begin
                    nxt_state = S_DONE;
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
            S_ERR1: begin
                nxt_state = S_ERR2;
            end
            S_IDLE, S_DONE, S_ERR2: begin
                nxt_state = S_IDLE;
                if (accept) begin
                    nxt_idx = a_idx;
                    nxt_wr  = HWRITE;
                    if (a_err) begin
                        nxt_state = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        nxt_state = S_WAIT;
                        nxt_cnt   = CW'(WAIT_STATES - 1);
                    end else begin
                        nxt_state = S_DONE;
                    end
                end
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    // Read data for the upcoming DONE cycle; a write completing this cycle to the same word is forwarded.
    always_comb begin
        bypass  = (state == S_DONE) && wr_q && (idx_q == nxt_idx);
        rd_word = mem[nxt_idx];
        for (int b = 0; b < NB; b++) begin
            if (bypass && HWSTRB[b]) begin
                rd_word[b*8 +: 8] = HWDATA[b*8 +: 8];
            end
        end
        nxt_rdata = ((nxt_state == S_DONE) && !nxt_wr) ? rd_word : '0;
    end

    // Transfer FSM with registered bus responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            HREADYEXT <= 1'b1;
            HRESPEXT  <= 1'b0;
            HRDATAEXT <= '0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            idx_q     <= nxt_idx;
            wr_q      <= nxt_wr;
            HREADYEXT <= (nxt_state != S_WAIT) && (nxt_state != S_ERR1);
            HRESPEXT  <= (nxt_state == S_ERR1) || (nxt_state == S_ERR2);
            HRDATAEXT <= nxt_rdata;
        end
    end

    // Byte-strobed memory update at the end of a write DONE cycle; contents survive reset.
    always_ff @(posedge clk) begin
        if ((state == S_DONE) && wr_q) begin
            for (int b = 0; b < NB; b++) begin
                if (HWSTRB[b]) begin
                    mem[idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahbextram.sv
// tb_ahbextram: two instances (2 wait states and 0 wait states) driven by shared stimulus.
// Each instance has its own HREADY, formed from its own HREADYEXT and a random stall enable.
// A transaction-level model tracks each instance's data phase and memory contents.
module tb_ahbextram;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          SZ   = 32768;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic        hr_en;

    logic        hready0, hready1;
    logic        rdy0, rdy1, resp0, resp1;
    logic [63:0] rd0, rd1;

    assign hready0 = hr_en & rdy0;
    assign hready1 = hr_en & rdy1;

    ahbextram #(.WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset(rst), .HSELEXT(sel), .HADDR(addr), .HTRANS(trans),
        .HWRITE(write), .HSIZE(size), .HBURST(burst), .HREADY(hready0),
        .HWDATA(wdata), .HWSTRB(strb), .HRDATAEXT(rd0), .HREADYEXT(rdy0), .HRESPEXT(resp0)
    );

    ahbextram #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst), .HSELEXT(sel), .HADDR(addr), .HTRANS(trans),
        .HWRITE(write), .HSIZE(size), .HBURST(burst), .HREADY(hready1),
        .HWDATA(wdata), .HWSTRB(strb), .HRDATAEXT(rd1), .HREADYEXT(rdy1), .HRESPEXT(resp1)
    );

    int checks   = 0;
    int failures = 0;

    // Model: index 0 is the 2-wait-state instance, index 1 the 0-wait-state one.
    // kind: 0 no transfer in data phase, 1 OKAY transfer, 2 ERROR response.
    // left: cycles of the data phase still to go after the current one.
    int          kind [2];
    int          left [2];
    bit          mwr  [2];
    int          midx [2];
    logic [63:0] mm   [2][4096];
    logic [7:0]  mv   [2][4096];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
        longint unsigned av = 64'(a);
        longint unsigned lo = 64'(BASE);
        longint unsigned hi = lo + 64'(SZ);
        longint unsigned al = 64'(1) << s;
        if (av < lo) return 1'b1;
        if (av >= hi) return 1'b1;
        if (s > 3'd3) return 1'b1;
        if ((av % al) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            kind[i] = 0;
            left[i] = 0;
        end
    endfunction

    function automatic void step_one(input int i);
        int ws = (i == 0) ? 2 : 0;
        if (!(kind[i] == 0 || left[i] == 0)) begin
            left[i] = left[i] - 1;
            return;
        end
        if (kind[i] == 1 && mwr[i]) begin
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) begin
                    mm[i][midx[i]][b*8 +: 8] = wdata[b*8 +: 8];
                    mv[i][midx[i]][b] = 1'b1;
                end
            end
        end
        if (sel && hr_en && trans[1]) begin
            if (is_err(addr, size)) begin
                kind[i] = 2;
                left[i] = 1;
            end else begin
                kind[i] = 1;
                left[i] = ws;
                mwr[i]  = write;
                midx[i] = int'((addr - BASE) >> 3);
            end
        end else begin
            kind[i] = 0;
        end
    endfunction

    task automatic compare();
        logic        gr, gs, er, es, rdph;
        logic [63:0] gd, ed, msk;
        for (int i = 0; i < 2; i++) begin
            gr   = (i == 0) ? rdy0 : rdy1;
            gs   = (i == 0) ? resp0 : resp1;
            gd   = (i == 0) ? rd0 : rd1;
            er   = (kind[i] == 0) || (left[i] == 0);
            es   = (kind[i] == 2);
            rdph = (kind[i] == 1) && !mwr[i] && (left[i] == 0);
            ed   = '0;
            msk  = '1;
            if (rdph) begin
                ed = mm[i][midx[i]];
                for (int b = 0; b < 8; b++) begin
                    msk[b*8 +: 8] = mv[i][midx[i]][b] ? 8'hFF : 8'h00;
                end
            end
            chk((i == 0) ? "model ws2 hreadyext" : "model ws0 hreadyext", 64'(gr), 64'(er));
            chk((i == 0) ? "model ws2 hrespext" : "model ws0 hrespext", 64'(gs), 64'(es));
            chk((i == 0) ? "model ws2 hrdataext" : "model ws0 hrdataext", gd & msk, ed & msk);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            step_one(0);
            step_one(1);
        end
        @(negedge clk);
        compare();
    endtask

    // One isolated transfer with literal checks of the response sequence.
    // ek: 0 OKAY write, 1 OKAY read expecting exp, 2 ERROR.
    task automatic xfer(input logic [31:0] a, input bit w, input logic [2:0] sz,
                        input logic [63:0] d, input logic [7:0] s, input int ek,
                        input logic [63:0] exp, input string nm);
        sel = 1'b1; addr = a; trans = 2'b10; write = w; size = sz;
        wdata = d; strb = s; hr_en = 1'b1;
        cycle();
        sel = 1'b0; trans = 2'b00;
        if (ek == 2) begin
            chk({nm, " ws2 c1 ready"}, 64'(rdy0), 64'd0);
            chk({nm, " ws2 c1 resp"},  64'(resp0), 64'd1);
            chk({nm, " ws0 c1 ready"}, 64'(rdy1), 64'd0);
            chk({nm, " ws0 c1 resp"},  64'(resp1), 64'd1);
        end else begin
            chk({nm, " ws2 c1 ready"}, 64'(rdy0), 64'd0);
            chk({nm, " ws0 c1 ready"}, 64'(rdy1), 64'd1);
            chk({nm, " ws0 c1 resp"},  64'(resp1), 64'd0);
            if (ek == 1) chk({nm, " ws0 rdata"}, rd1, exp);
        end
        cycle();
        if (ek == 2) begin
            chk({nm, " ws2 c2 ready"}, 64'(rdy0), 64'd1);
            chk({nm, " ws2 c2 resp"},  64'(resp0), 64'd1);
            chk({nm, " ws0 c2 ready"}, 64'(rdy1), 64'd1);
            chk({nm, " ws0 c2 resp"},  64'(resp1), 64'd1);
        end else begin
            chk({nm, " ws2 c2 ready"}, 64'(rdy0), 64'd0);
        end
        cycle();
        chk({nm, " ws2 c3 ready"}, 64'(rdy0), 64'd1);
        chk({nm, " ws2 c3 resp"},  64'(resp0), 64'd0);
        if (ek == 1) chk({nm, " ws2 rdata"}, rd0, exp);
        cycle();
        chk({nm, " ws2 c4 rdata"}, rd0, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 4096; w++) mv[i][w] = 8'h00;
        end
        model_reset();
        rst = 1'b1; sel = 1'b0; addr = BASE; trans = 2'b00; write = 1'b0;
        size = 3'd3; burst = 3'd0; wdata = '0; strb = '0; hr_en = 1'b1;
        cycle();
        cycle();
        chk("reset ws2 ready", 64'(rdy0), 64'd1);
        chk("reset ws2 resp",  64'(resp0), 64'd0);
        chk("reset ws2 rdata", rd0, 64'd0);
        chk("reset ws0 rdata", rd1, 64'd0);
        rst = 1'b0;
        cycle();

        // Full-word and byte-strobed writes, then reads.
        xfer(32'h8000_0000, 1'b1, 3'd3, 64'h0, 8'hFF, 0, 64'h0, "clear w0");
        xfer(32'h8000_0000, 1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 64'h0, "strb wr");
        xfer(32'h8000_0000, 1'b0, 3'd3, 64'h0, 8'h00, 1, 64'h0000_0000_FFFF_FFFF, "strb rd");
        xfer(32'h8000_0010, 1'b1, 3'd3, 64'h1122_3344_5566_7788, 8'hFF, 0, 64'h0, "wr 10");
        xfer(32'h8000_0010, 1'b0, 3'd3, 64'h0, 8'h00, 1, 64'h1122_3344_5566_7788, "rd 10");

        // Illegal accesses leave memory untouched.
        xfer(32'h8000_8000, 1'b0, 3'd3, 64'h0, 8'h00, 2, 64'h0, "err range");
        xfer(32'h8000_0004, 1'b1, 3'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 2, 64'h0, "err align");
        xfer(32'h8000_0000, 1'b0, 3'd3, 64'h0, 8'h00, 1, 64'h0000_0000_FFFF_FFFF, "rd after err");
        xfer(32'h8000_0008, 1'b0, 3'd5, 64'h0, 8'h00, 2, 64'h0, "err size");

        // IDLE and BUSY with select high, and NONSEQ while HREADY is low, are not accepted.
        sel = 1'b1; addr = 32'h8000_0010; trans = 2'b00; write = 1'b0;
        cycle();
        chk("idle ws2 ready", 64'(rdy0), 64'd1);
        chk("idle ws0 resp",  64'(resp1), 64'd0);
        trans = 2'b01;
        cycle();
        chk("busy ws2 ready", 64'(rdy0), 64'd1);
        chk("busy ws0 rdata", rd1, 64'd0);
        trans = 2'b10; hr_en = 1'b0;
        cycle();
        chk("hready low ws2 ready", 64'(rdy0), 64'd1);
        chk("hready low ws0 rdata", rd1, 64'd0);
        sel = 1'b0; trans = 2'b00; hr_en = 1'b1;
        cycle();

        // Reset in the middle of a write: outputs recover at once, write dropped.
        sel = 1'b1; addr = 32'h8000_0010; trans = 2'b10; write = 1'b1; size = 3'd3;
        wdata = 64'hDEAD_BEEF_0BAD_F00D; strb = 8'hFF;
        cycle();
        sel = 1'b0; trans = 2'b00;
        chk("pre-reset ws2 ready", 64'(rdy0), 64'd0);
        rst = 1'b1;
        model_reset();
        #1;
        chk("async reset ws2 ready", 64'(rdy0), 64'd1);
        chk("async reset ws2 resp",  64'(resp0), 64'd0);
        chk("async reset ws2 rdata", rd0, 64'd0);
        chk("async reset ws0 ready", 64'(rdy1), 64'd1);
        cycle();
        rst = 1'b0;
        cycle();
        xfer(32'h8000_0010, 1'b0, 3'd3, 64'h0, 8'h00, 1, 64'h1122_3344_5566_7788, "rd after rst");

        // Back-to-back write then read of the same word (zero-wait instance forwards).
        xfer(32'h8000_0020, 1'b1, 3'd3, 64'h0101_0101_0101_0101, 8'hFF, 0, 64'h0, "wr 20 old");
        sel = 1'b1; addr = 32'h8000_0020; trans = 2'b10; write = 1'b1;
        wdata = 64'hCAFE_F00D_1234_5678; strb = 8'hFF;
        cycle();
        write = 1'b0;
        cycle();
        sel = 1'b0; trans = 2'b00;
        chk("b2b ws0 ready", 64'(rdy1), 64'd1);
        chk("b2b ws0 rdata", rd1, 64'hCAFE_F00D_1234_5678);
        repeat (4) cycle();
        xfer(32'h8000_0020, 1'b0, 3'd3, 64'h0, 8'h00, 1, 64'hCAFE_F00D_1234_5678, "rd 20 new");

        // Randomized traffic, checked every cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            int off;
            int pick;
            sel   = ($urandom % 8) != 0;
            trans = 2'($urandom);
            write = 1'($urandom);
            burst = 3'($urandom);
            size  = (($urandom % 100) < 5) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            off   = int'($urandom_range(0, 255));
            if (($urandom % 100) < 85) off = off & ~((1 << size) - 1);
            pick  = int'($urandom % 100);
            if (pick < 6)       addr = BASE - 32'($urandom_range(1, 64));
            else if (pick < 12) addr = BASE + 32'(SZ) + 32'(off);
            else                addr = BASE + 32'(off);
            wdata = {$urandom, $urandom};
            strb  = 8'($urandom);
            hr_en = ($urandom % 10) != 0;
            cycle();
        end
        sel = 1'b0; trans = 2'b00; hr_en = 1'b1;
        repeat (5) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
